// File: rtl/sd_cmd_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_serializer
// Description : SD host command-line engine. On an accepted start it captures
//               the command fields and argument, sends a 48-bit CMD frame with
//               CRC7 (MSB first, one bit per bit_tick), waits for and receives
//               the card response (48 or 136 bits), checks it and reports
//               completion and sticky error status.
// Optional    : SD_CMD_BUSY_WAIT_EN - when defined, response type 11 waits in
//               BUSYWAIT until DAT0 is released before signalling done. When
//               undefined, type 11 behaves as type 10 and dat0_in_i is ignored.
// Ports       : clk_i, rst_ni            clock, async active-low reset
//               bit_tick_i               SD-clock bit strobe
//               start_i, cmd_index_i, argument_i, resp_type_sel_i,
//               crc_check_en_i, index_check_en_i   command request
//               cmd_in_i, dat0_in_i      sampled CMD / DAT0 lines
//               cmd_out_o, cmd_oe_o      CMD line drive value / enable
//               busy_o, done_o           status / completion pulse
//               resp_data_o              received frame bits [39:8]
//               timeout_err_o, crc_err_o, index_err_o, end_bit_err_o
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_serializer #(
    parameter int NCR_MAX = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bit_tick_i,
    input  logic        start_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] argument_i,
    input  logic [1:0]  resp_type_sel_i,
    input  logic        crc_check_en_i,
    input  logic        index_check_en_i,
    input  logic        cmd_in_i,
    input  logic        dat0_in_i,
    output logic        cmd_out_o,
    output logic        cmd_oe_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] resp_data_o,
    output logic        timeout_err_o,
    output logic        crc_err_o,
    output logic        index_err_o,
    output logic        end_bit_err_o
);

    // One counter serves TX bit position, response timeout and RX bit count.
    localparam int CNT_W = (NCR_MAX > 135) ? $clog2(NCR_MAX + 1) : 8;
    localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(47);
    localparam logic [CNT_W-1:0] NCR_LAST   = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] RX48_LAST  = CNT_W'(46);
    localparam logic [CNT_W-1:0] RX136_LAST = CNT_W'(134);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX       = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_RX       = 3'd3,
`ifdef SD_CMD_BUSY_WAIT_EN
        ST_BUSYWAIT = 3'd4,
`endif
        ST_DONE     = 3'd5
    } state_t;

    // CRC7, generator x^7 + x^3 + 1, register starts at zero, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [47:0]      frame_q, frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [46:0]      rx_q, rx_d;
    logic [5:0]       idx_q, idx_d;
    logic [1:0]       type_q, type_d;
    logic             crc_en_q, crc_en_d;
    logic             idx_en_q, idx_en_d;
    logic [31:0]      resp_q, resp_d;
    logic             to_err_q, to_err_d;
    logic             crc_err_q, crc_err_d;
    logic             idx_err_q, idx_err_d;
    logic             eb_err_q, eb_err_d;

    logic [47:0]      w_rx_next;
    logic             w_rx_last;
    logic             w_is_r48;
    logic [39:0]      w_tx_head;

    // Incoming bit appended to the history; for 136-bit responses only the
    // trailing 48 bits are retained, which is all resp_data needs.
    assign w_rx_next = {rx_q, cmd_in_i};
    assign w_is_r48  = (type_q != 2'b01);
    assign w_rx_last = w_is_r48 ? (cnt_q == RX48_LAST) : (cnt_q == RX136_LAST);
    assign w_tx_head = {2'b01, cmd_index_i, argument_i};

`ifndef SD_CMD_BUSY_WAIT_EN
    logic unused_dat0;
    assign unused_dat0 = dat0_in_i;
`endif

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        idx_d     = idx_q;
        type_d    = type_q;
        crc_en_d  = crc_en_q;
        idx_en_d  = idx_en_q;
        resp_d    = resp_q;
        to_err_d  = to_err_q;
        crc_err_d = crc_err_q;
        idx_err_d = idx_err_q;
        eb_err_d  = eb_err_q;

        case (state_q)
            ST_IDLE: begin
                // Any bit_tick coincident with acceptance is deliberately
                // ignored: the start bit must be shown for a full tick.
                if (start_i) begin
                    idx_d     = cmd_index_i;
                    type_d    = resp_type_sel_i;
                    crc_en_d  = crc_check_en_i;
                    idx_en_d  = index_check_en_i;
                    to_err_d  = 1'b0;
                    crc_err_d = 1'b0;
                    idx_err_d = 1'b0;
                    eb_err_d  = 1'b0;
                    frame_d   = {w_tx_head, crc7(w_tx_head), 1'b1};
                    cnt_d     = '0;
                    state_d   = ST_TX;
                end
            end

            ST_TX: begin
                if (bit_tick_i) begin
                    if (cnt_q == TX_LAST) begin
                        cnt_d   = '0;
                        state_d = (type_q == 2'b00) ? ST_DONE : ST_WAIT_RSP;
                    end else begin
                        frame_d = {frame_q[46:0], 1'b1};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end

            ST_WAIT_RSP: begin
                // A low CMD on the final allowed tick is still a start bit.
                if (bit_tick_i) begin
                    if (!cmd_in_i) begin
                        rx_d    = '0;
                        cnt_d   = '0;
                        state_d = ST_RX;
                    end else if (cnt_q == NCR_LAST) begin
                        to_err_d = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_RX: begin
                if (bit_tick_i) begin
                    rx_d = w_rx_next[46:0];
                    if (w_rx_last) begin
                        eb_err_d = ~cmd_in_i;
                        if (w_is_r48) begin
                            crc_err_d = crc_en_q &&
                                        (w_rx_next[7:1] != crc7(w_rx_next[47:8]));
                            idx_err_d = idx_en_q && (w_rx_next[45:40] != idx_q);
                        end
                        resp_d  = w_rx_next[39:8];
`ifdef SD_CMD_BUSY_WAIT_EN
                        state_d = (type_q == 2'b11) ? ST_BUSYWAIT : ST_DONE;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

`ifdef SD_CMD_BUSY_WAIT_EN
            ST_BUSYWAIT: begin
                if (bit_tick_i && dat0_in_i) begin
                    state_d = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            frame_q   <= '1;
            cnt_q     <= '0;
            rx_q      <= '0;
            idx_q     <= '0;
            type_q    <= '0;
            crc_en_q  <= 1'b0;
            idx_en_q  <= 1'b0;
            resp_q    <= '0;
            to_err_q  <= 1'b0;
            crc_err_q <= 1'b0;
            idx_err_q <= 1'b0;
            eb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            idx_q     <= idx_d;
            type_q    <= type_d;
            crc_en_q  <= crc_en_d;
            idx_en_q  <= idx_en_d;
            resp_q    <= resp_d;
            to_err_q  <= to_err_d;
            crc_err_q <= crc_err_d;
            idx_err_q <= idx_err_d;
            eb_err_q  <= eb_err_d;
        end
    end

    // Decoded straight from the state register so that reset releases the
    // CMD line asynchronously.
    assign cmd_oe_o      = (state_q == ST_TX);
    assign cmd_out_o     = (state_q == ST_TX) ? frame_q[47] : 1'b1;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign resp_data_o   = resp_q;
    assign timeout_err_o = to_err_q;
    assign crc_err_o     = crc_err_q;
    assign index_err_o   = idx_err_q;
    assign end_bit_err_o = eb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_serializer
// Description : Self-checking bench for sd_cmd_serializer. A card model drives
//               responses; monitors compare transmitted frames and completion
//               status against expectations queued by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_serializer;

    localparam int NCR = 64;

    logic        clk;
    logic        rst_n;
    logic        bit_tick;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] argument;
    logic [1:0]  resp_type_sel;
    logic        crc_check_en;
    logic        index_check_en;
    logic        cmd_in;
    logic        dat0_in;
    logic        cmd_out;
    logic        cmd_oe;
    logic        busy;
    logic        done;
    logic [31:0] resp_data;
    logic        timeout_err;
    logic        crc_err;
    logic        index_err;
    logic        end_bit_err;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_mode = 0;
    logic [31:0] model_resp = '0;

    logic [47:0] exp_frames[$];
    logic [35:0] exp_done[$];   // {resp_data, timeout, crc, index, end_bit}

    sd_cmd_serializer #(.NCR_MAX(NCR)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .bit_tick_i       (bit_tick),
        .start_i          (start),
        .cmd_index_i      (cmd_index),
        .argument_i       (argument),
        .resp_type_sel_i  (resp_type_sel),
        .crc_check_en_i   (crc_check_en),
        .index_check_en_i (index_check_en),
        .cmd_in_i         (cmd_in),
        .dat0_in_i        (dat0_in),
        .cmd_out_o        (cmd_out),
        .cmd_oe_o         (cmd_oe),
        .busy_o           (busy),
        .done_o           (done),
        .resp_data_o      (resp_data),
        .timeout_err_o    (timeout_err),
        .crc_err_o        (crc_err),
        .index_err_o      (index_err),
        .end_bit_err_o    (end_bit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bit_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bit_tick = (tick_mode == 0) ? 1'b1 : ($urandom_range(2) == 0);
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of polynomial long division by x^7+x^3+1 (0x89).
    function automatic logic [6:0] ref_crc(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, ref_crc({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] card_r48(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b00, idx, arg, ref_crc({2'b00, idx, arg}), 1'b1};
    endfunction

    task automatic scramble_fields();
        cmd_index      = 6'($urandom);
        argument       = $urandom;
        resp_type_sel  = 2'($urandom);
        crc_check_en   = 1'($urandom);
        index_check_en = 1'($urandom);
    endtask

    // Called at posedge+2; returns at posedge+2 after the edge that consumed a tick.
    task automatic consume();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bit_tick && g < 500);
        if (!bit_tick) chk("tick_wait_expired", 0, 1);
        @(posedge clk);
        #2;
    endtask

    // Transmit monitor: collects cmd_out on every tick while driving.
    initial begin : tx_mon
        int n;
        logic [47:0] bits;
        n = 0;
        bits = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (n > 0) begin
                    if (exp_frames.size() > 0) void'(exp_frames.pop_front());
                    n = 0;
                end
            end else if (cmd_oe) begin
                if (bit_tick) begin
                    bits = {bits[46:0], cmd_out};
                    n++;
                end
            end else if (n > 0) begin
                chk("tx_tick_count", 64'(n), 64'd48);
                if (exp_frames.size() == 0) chk("tx_unexpected_frame", 1, 0);
                else chk("tx_frame", bits, exp_frames.pop_front());
                n = 0;
            end
        end
    end

    // Completion monitor.
    initial begin : done_mon
        logic prev_done;
        logic [35:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                chk("done_one_cycle", prev_done, 0);
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = exp_done.pop_front();
                    chk("resp_data", resp_data, e[35:4]);
                    chk("timeout_err", timeout_err, e[3]);
                    chk("crc_err", crc_err, e[2]);
                    chk("index_err", index_err, e[1]);
                    chk("end_bit_err", end_bit_err, e[0]);
                    chk("busy_in_done", busy, 1);
                end
            end
            prev_done = rst_n & done;
        end
    end

    // dly < 0: card never answers. lit_frame used when use_lit is set.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                           input logic ce, input logic ie, input int dly, input logic [135:0] rsp,
                           input bit busy_test, input bit use_lit, input logic [47:0] lit_frame);
        logic [47:0] f48;
        logic [35:0] e;
        int nb;
        int g;
        bit early;
        exp_frames.push_back(use_lit ? lit_frame : ref_frame(idx, arg));
        if (typ == 2'b00) begin
            e = {model_resp, 4'b0000};
        end else if (dly < 0) begin
            e = {model_resp, 4'b1000};
        end else if (typ == 2'b01) begin
            model_resp = rsp[39:8];
            e = {rsp[39:8], 3'b000, ~rsp[0]};
        end else begin
            f48 = rsp[47:0];
            model_resp = f48[39:8];
            e = {f48[39:8], 1'b0, ce && (f48[7:1] != ref_crc(f48[47:8])),
                 ie && (f48[45:40] != idx), ~f48[0]};
        end
        exp_done.push_back(e);

        start = 1'b1;
        cmd_index = idx;
        argument = arg;
        resp_type_sel = typ;
        crc_check_en = ce;
        index_check_en = ie;
        @(posedge clk);
        #2;
        start = 1'b0;
        scramble_fields();
        chk("accept_busy", busy, 1);
        chk("accept_cmd_oe", cmd_oe, 1);
        chk("accept_start_bit", cmd_out, 0);

        g = 0;
        while (cmd_oe && g < 5000) begin
            start = ($urandom_range(7) == 0);
            if (start) scramble_fields();
            @(posedge clk);
            #2;
            g++;
        end
        start = 1'b0;
        chk("tx_end_wait", cmd_oe, 0);

        if (typ == 2'b00) begin
            chk("noresp_done_after_tx", done, 1);
        end else if (dly < 0) begin
            early = 1'b0;
            for (int k = 1; k <= NCR; k++) begin
                consume();
                if (k < NCR && done) early = 1'b1;
            end
            chk("timeout_not_early", early, 0);
            chk("timeout_done", done, 1);
            chk("timeout_flag", timeout_err, 1);
        end else begin
            for (int k = 0; k < dly; k++) consume();
            nb = (typ == 2'b01) ? 136 : 48;
            for (int b = nb - 1; b >= 0; b--) begin
                cmd_in = rsp[b];
                if (b == 0 && busy_test) dat0_in = 1'b0;
                consume();
            end
            cmd_in = 1'b1;
            if (busy_test) begin
`ifdef SD_CMD_BUSY_WAIT_EN
                early = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    if (done) early = 1'b1;
                    consume();
                end
                if (done) early = 1'b1;
                chk("busywait_holds_done", early, 0);
                dat0_in = 1'b1;
                consume();
                chk("busywait_done_on_release", done, 1);
`else
                chk("type11_done_after_rx", done, 1);
                dat0_in = 1'b1;
`endif
            end else begin
                g = 0;
                while (!done && g < 5000) begin
                    @(posedge clk);
                    #2;
                    g++;
                end
                chk("done_wait", done, 1);
            end
        end
        @(posedge clk);
        #2;
        chk("idle_after_done", busy, 0);
    endtask

    task automatic reset_mid_tx(input logic [5:0] idx, input logic [31:0] arg);
        exp_frames.push_back(ref_frame(idx, arg));
        start = 1'b1;
        cmd_index = idx;
        argument = arg;
        resp_type_sel = 2'b10;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int k = 0; k < 20; k++) consume();
        rst_n = 1'b0;
        #1;
        chk("rst_cmd_oe", cmd_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_out", cmd_out, 1);
        chk("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_resp = '0;
        chk("rst_resp_data", resp_data, 0);
        chk("rst_errors", {timeout_err, crc_err, index_err, end_bit_err}, 0);
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        logic [135:0] r;
        logic [159:0] wide;
        logic [5:0] ridx;
        logic [31:0] rarg;
        logic [1:0] rtyp;
        logic [47:0] f;
        int c;
        int d;

        rst_n = 1'b0;
        start = 1'b0;
        cmd_in = 1'b1;
        dat0_in = 1'b1;
        cmd_index = '0;
        argument = '0;
        resp_type_sel = '0;
        crc_check_en = 1'b0;
        index_check_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_cmd_out", cmd_out, 1);
        chk("reset_cmd_oe", cmd_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_resp_data", resp_data, 0);
        chk("reset_errors", {timeout_err, crc_err, index_err, end_bit_err}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // CMD0, no response, maximum tick rate.
        run_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 0, '0, 1'b0, 1'b1, 48'h40_0000_0000_95);

        tick_mode = 1;
        // CMD8 with a correct R7-style response.
        r = '0;
        r[47:0] = 48'h08_0000_01AA_13;
        run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, 5, r, 1'b0, 1'b1, 48'h48_0000_01AA_87);
        chk("cmd8_resp_data", resp_data, 32'h1AA);

        // No answer: timeout on the 64th tick.
        run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, -1, '0, 1'b0, 1'b1, 48'h48_0000_01AA_87);

        // Corrupted CRC byte.
        r[47:0] = 48'h08_0000_01AA_15;
        run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, 3, r, 1'b0, 1'b0, '0);
        chk("crc_corrupt_flag", crc_err, 1);

        // Wrong index, valid CRC.
        r[47:0] = {8'h09, 32'h1AA, ref_crc({8'h09, 32'h1AA}), 1'b1};
        run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, 2, r, 1'b0, 1'b0, '0);
        chk("index_corrupt_flag", index_err, 1);
        chk("index_corrupt_no_crc", crc_err, 0);

        // End bit forced low.
        r[47:0] = 48'h08_0000_01AA_12;
        run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, 0, r, 1'b0, 1'b0, '0);
        chk("end_bit_flag", end_bit_err, 1);

        // Start bit arriving on the last allowed tick.
        r[47:0] = 48'h08_0000_01AA_13;
        run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, NCR - 1, r, 1'b0, 1'b0, '0);
        chk("late_start_no_timeout", timeout_err, 0);

        // Busy signalling after an R1b-style response.
        r[47:0] = card_r48(6'd7, 32'h0000_0900);
        run_cmd(6'd7, 32'h1234_0000, 2'b11, 1'b1, 1'b1, 4, r, 1'b1, 1'b0, '0);

        // Reset mid-TX, then a full frame afterwards at maximum rate.
        reset_mid_tx(6'd17, 32'hDEAD_BEEF);
        tick_mode = 0;
        r[47:0] = card_r48(6'd17, 32'h0000_0900);
        run_cmd(6'd17, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b1, 1, r, 1'b0, 1'b0, '0);

        // 136-bit response.
        wide = {$urandom, $urandom, $urandom, $urandom, $urandom};
        r = wide[135:0];
        r[135] = 1'b0;
        r[0] = 1'b1;
        run_cmd(6'd2, 32'h0, 2'b01, 1'b1, 1'b1, 2, r, 1'b0, 1'b0, '0);

        for (int n = 0; n < 25; n++) begin
            tick_mode = $urandom_range(1);
            ridx = 6'($urandom);
            rarg = $urandom;
            rtyp = 2'($urandom);
            d = $urandom_range(30);
            if ($urandom_range(9) == 0) d = -1;
            r = '0;
            if (rtyp == 2'b01) begin
                wide = {$urandom, $urandom, $urandom, $urandom, $urandom};
                r = wide[135:0];
                r[135] = 1'b0;
                r[0] = ($urandom_range(5) != 0);
            end else begin
                f = card_r48(ridx, $urandom);
                c = $urandom_range(7);
                if (c == 0) f[$urandom_range(7, 1)] ^= 1'b1;
                if (c == 1) f[45:40] = f[45:40] ^ 6'($urandom_range(63, 1));
                if (c == 2) f[0] = 1'b0;
                r[47:0] = f;
            end
            run_cmd(ridx, rarg, rtyp, 1'($urandom), 1'($urandom), d, r, 1'b0, 1'b0, '0);
        end

        repeat (4) @(posedge clk);
        chk("frames_left", 64'(exp_frames.size()), 0);
        chk("dones_left", 64'(exp_done.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_cmd_serializer.md
# sd_cmd_serializer

Command-line engine of the SD host, directly downstream of the Command Register (offset 00Eh) and the Argument register. On a start strobe it captures the command index, response-type and check-enable fields plus the 32-bit argument. It then serialises a 48-bit CMD frame with CRC7 onto the CMD line, one bit per SD-clock tick. It receives and checks the card response, and reports completion and error status back to the register file.

## Interface
- NCR_MAX, 64: bit-ticks allowed between end of the command and the response start bit.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- bit_tick  in  1  one-cycle pulse from the SD clock divider; all CMD-line activity advances only on it.
- start  in  1  issue request; accepted only in IDLE.
- cmd_index  in  6  CommandIndex field.
- argument  in  32  command argument.
- resp_type_sel  in  2  ResponseTypeSelect: 00 none, 01 136-bit, 10 48-bit, 11 48-bit with busy.
- crc_check_en  in  1  CommandCRCCheckEnable.
- index_check_en  in  1  CommandIndexCheckEnable.
- cmd_in  in  1  sampled CMD line.
- dat0_in  in  1  sampled DAT0, used for busy detection.
- cmd_out  out  1  CMD drive value.
- cmd_oe  out  1  CMD output enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- resp_data  out  32  bits [39:8] of the received frame (frame bit 0 = end bit).
- timeout_err, crc_err, index_err, end_bit_err  out  1 each  sticky status bits; cleared when the next start is accepted.

## Operation
- States: IDLE, TX, WAIT_RSP, RX, BUSYWAIT, DONE.
- **IDLE**:
  - cmd_oe=0, cmd_out=1.
  - When start=1: latch all inputs, clear error bits, build the frame, go to TX.
- **Frame** (transmitted MSB first):
  - bit47 = 0 (start bit), bit46 = 1 (transmission bit).
  - [45:40] = cmd_index, [39:8] = argument.
  - [7:1] = CRC7 over bits 47..8, polynomial x^7+x^3+1, register initialised to 0.
  - bit0 = 1 (end bit).
- **TX**:
  - cmd_oe=1; cmd_out shows the current frame bit; each bit_tick advances one bit.
  - On the 48th bit_tick: cmd_oe=0.
  - Next state is DONE if resp_type_sel=00, otherwise WAIT_RSP.
- **WAIT_RSP**:
  - A bit_tick with cmd_in=0 counts as the start bit; go to RX.
  - After NCR_MAX bit_ticks with cmd_in high: set timeout_err, go to DONE.
- **RX**:
  - Shift cmd_in on each bit_tick, for 47 more bits (48-bit responses) or 135 more (136-bit).
  - After the last bit:
    - end_bit_err if the end bit = 0.
    - crc_err if crc_check_en and received [7:1] ≠ CRC7 over received bits 47..8; evaluated for 48-bit responses only.
    - index_err if index_check_en and received [45:40] ≠ latched cmd_index; 48-bit responses only.
  - resp_data is updated at RX exit.
  - Next state is BUSYWAIT if resp_type_sel=11 and SD_CMD_BUSY_WAIT_EN is defined, otherwise DONE.
- **BUSYWAIT**: stay until a bit_tick sees dat0_in=1, then go to DONE.
- **DONE**: done=1 for one clk, then IDLE.
- start while busy=1 is ignored; latched inputs never change mid-command.
- Input fields change freely after acceptance.

## Timing
- Reset values: cmd_out=1, cmd_oe=0, busy=0, done=0, resp_data=0, all error bits 0, state IDLE.
- rst low mid-command: immediate return to IDLE; CMD line released in the same cycle, asynchronously.
- start sampled at edge t: busy=1, cmd_oe=1, cmd_out=0 from t+1.
- Frame duration: exactly 48 bit_ticks; the end bit is held until the 48th tick.
- No-response command: done asserted 1 clk after the 48th tick.
- bit_tick and start in the same cycle as acceptance: the tick does not advance the frame.
- bit_tick held high continuously: one bit per clk (maximum rate).
- Timeout counter: reset on entry to WAIT_RSP; timeout_err is set on the NCR_MAX-th tick.
- Errors are stable when done pulses and hold until the next accepted start.

## Configuration
- SD_CMD_BUSY_WAIT_EN defined: type 11 enters BUSYWAIT after RX; done is withheld while dat0_in=0.
- SD_CMD_BUSY_WAIT_EN undefined: no BUSYWAIT state; type 11 behaves exactly as type 10; dat0_in is ignored.

## Test plan
- CMD0:
  - Stimulus: index 0, arg 0, type 00.
  - Required: cmd_out serial 0x40_0000_0000_95; cmd_oe high for exactly 48 ticks; done 1 clk later; no errors.
- CMD8:
  - Stimulus: arg 0x000001AA, type 10, both checks enabled, card returns 0x08_0000_01AA_13.
  - Required: TX 0x48_0000_01AA_87; resp_data=0x000001AA; no errors.
- Timeout:
  - Stimulus: same CMD8, cmd_in held high.
  - Required: timeout_err=1 and done after 64 ticks in WAIT_RSP.
- Corrupted response:
  - Stimulus: response CRC byte 0x13 → 0x15.
  - Required: crc_err=1.
  - Then index field 0x09 returned with index_check_en=1: index_err=1.
  - Then end bit forced 0: end_bit_err=1.
- Busy wait (macro defined):
  - Stimulus: type 11; dat0_in low for 20 ticks after the response.
  - Required: done only after dat0_in rises.
  - Macro undefined: done right after RX.
- Reset mid-TX:
  - Stimulus: rst low at tick 20.
  - Required: cmd_oe=0, busy=0 immediately.
  - New start after reset: full correct frame.
